// File: rtl/alu_mult_sequencer_pkg.sv
// Shared definitions for the MULTU add-and-shift sequencer: state encodings
// and default sizing.
package alu_mult_sequencer_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_mult_sequencer_if.sv
// Request/result bus of the multiplier: operands and start in, busy/done and
// the HI/LO product out.
interface alu_mult_sequencer_if
  import alu_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, a, b, input busy, done, hi, lo);
  modport slave  (input start, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/alu_mult_product_reg.sv
// HI/LO product shift register. Each step folds the external adder's
// {carry, sum} in as the new HI and shifts the 2*WIDTH+1 value right by one.
module alu_mult_product_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_lo,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH:0] step_val;

  // The multiplier bits leave through lo[0] while product bits enter at the top.
  assign step_val = {add_cout, add_sum, lo};

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation order cannot change the result.
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= load_lo;
    end else if (shift_en) begin
      {hi, lo} <= step_val[2*WIDTH:1];
    end
  end

endmodule

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle unsigned multiplier controller: drives the shared ripple adder
// through WIDTH add-and-shift iterations to produce a 2*WIDTH-bit product.
module alu_mult_sequencer
  import alu_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_mult_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi, lo;
  logic             accept;
  logic             running;

  // A new request is only taken when no iteration is in flight.
  assign accept  = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign running = (state_q == RUN);

  always_comb begin
    // NOTE: the default assignment first means every path through the case
    // sets state_d, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == LAST_ITER) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= '0;
        mcand_q <= bus.a;
      end else if (running) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  alu_mult_product_reg #(.WIDTH(WIDTH)) u_product (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift_en (running),
    .load_lo  (bus.b),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .hi       (hi),
    .lo       (lo)
  );

  // Adder operands come straight from registers; the current lo[0] gates B.
  assign add_a   = hi;
  assign add_b   = lo[0] ? mcand_q : '0;
  assign add_cin = 1'b0;

  assign bus.busy = running;
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi;
  assign bus.lo   = lo;

endmodule
